// File: rtl/payload_engine_ctrl.sv
// rtl/payload_engine_ctrl.sv - packet payload sequencer for a bank of sticky-match engines
//
// Purpose: accepts a byte stream framed by s_sop/s_eop, clears the engines at
// packet start, broadcasts each payload byte to the engines, runs a few flush
// cycles so sticky end states settle, then reports the captured match vector
// and payload length through a valid/ready result port.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   s_data/s_valid/s_sop/s_eop/s_ready   payload byte stream in
//   eng_char/eng_char_vld     registered byte broadcast to the class decoders
//   eng_en, eng_sod           engine state-register enable and clear
//   eng_match                 sticky end-state outputs of the engines
//   res_valid/res_ready       result handshake
//   res_match/res_any/res_len captured result
//   drop_cnt                  stray beats discarded while idle (saturating)

module payload_engine_ctrl #(
  parameter int NUM_ENG   = 8,
  parameter int FLUSH_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  input  logic               s_sop,
  input  logic               s_eop,
  output logic               s_ready,
  output logic [7:0]         eng_char,
  output logic               eng_char_vld,
  output logic               eng_en,
  output logic               eng_sod,
  input  logic [NUM_ENG-1:0] eng_match,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [NUM_ENG-1:0] res_match,
  output logic               res_any,
  output logic [15:0]        res_len,
  output logic [15:0]        drop_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCAN,
    ST_FLUSH,
    ST_REPORT
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         flush_cnt_q, flush_cnt_d;
  logic [15:0]        len_q, len_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic [7:0]         eng_char_q, eng_char_d;
  logic               eng_char_vld_q, eng_char_vld_d;
  logic               eng_en_q, eng_en_d;
  logic               eng_sod_q, eng_sod_d;
  logic               res_valid_q, res_valid_d;
  logic [NUM_ENG-1:0] res_match_q, res_match_d;
  logic               res_any_q, res_any_d;
  logic [15:0]        res_len_q, res_len_d;
  logic               s_ready_int;

  // A sop beat in IDLE is held off (not accepted); it is consumed in SCAN.
  assign s_ready_int = ((state_q == ST_IDLE) && s_valid && !s_sop) ||
                       (state_q == ST_SCAN);

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    len_d          = len_q;
    drop_cnt_d     = drop_cnt_q;
    eng_char_d     = eng_char_q;
    eng_char_vld_d = 1'b0;
    eng_en_d       = 1'b0;
    eng_sod_d      = 1'b0;
    res_valid_d    = res_valid_q;
    res_match_d    = res_match_q;
    res_any_d      = res_any_q;
    res_len_d      = res_len_q;

    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          if (s_sop) begin
            state_d   = ST_CLEAR;
            eng_sod_d = 1'b1;
          end else if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end
      end
      ST_CLEAR: begin
        len_d   = 16'd0;
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        // Any s_sop seen here is just payload; only s_eop matters.
        if (s_valid) begin
          eng_char_d     = s_data;
          eng_char_vld_d = 1'b1;
          eng_en_d       = 1'b1;
          if (len_q != 16'hFFFF) begin
            len_d = len_q + 16'd1;
          end
          if (s_eop) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = 4'd0;
          end
        end
      end
      ST_FLUSH: begin
        // eng_* are registered, so the flush enables appear one cycle after
        // the FLUSH state cycles that request them.
        eng_en_d = 1'b1;
        if (flush_cnt_q == 4'(FLUSH_CYC - 1)) begin
          state_d     = ST_REPORT;
          res_valid_d = 1'b1;
          res_match_d = eng_match;
          res_any_d   = |eng_match;
          res_len_d   = len_q;
        end else begin
          flush_cnt_d = flush_cnt_q + 4'd1;
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      flush_cnt_q    <= 4'd0;
      len_q          <= 16'd0;
      drop_cnt_q     <= 16'd0;
      eng_char_q     <= 8'd0;
      eng_char_vld_q <= 1'b0;
      eng_en_q       <= 1'b0;
      eng_sod_q      <= 1'b0;
      res_valid_q    <= 1'b0;
      res_match_q    <= '0;
      res_any_q      <= 1'b0;
      res_len_q      <= 16'd0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      len_q          <= len_d;
      drop_cnt_q     <= drop_cnt_d;
      eng_char_q     <= eng_char_d;
      eng_char_vld_q <= eng_char_vld_d;
      eng_en_q       <= eng_en_d;
      eng_sod_q      <= eng_sod_d;
      res_valid_q    <= res_valid_d;
      res_match_q    <= res_match_d;
      res_any_q      <= res_any_d;
      res_len_q      <= res_len_d;
    end
  end

  // Control outputs follow rst immediately so the engines are held cleared
  // and idle for the whole reset interval, including the cycle before the
  // first reset edge; eng_sod_q itself resets low so it drops as rst drops.
  assign s_ready      = s_ready_int && !rst;
  assign eng_sod      = eng_sod_q || rst;
  assign eng_en       = eng_en_q && !rst;
  assign eng_char_vld = eng_char_vld_q && !rst;
  assign res_valid    = res_valid_q && !rst;
  assign eng_char     = eng_char_q;
  assign res_match    = res_match_q;
  assign res_any      = res_any_q;
  assign res_len      = res_len_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_payload_engine_ctrl.sv
// tb/tb_payload_engine_ctrl.sv - scoreboard bench for payload_engine_ctrl

module tb_payload_engine_ctrl;

  localparam int NUM_ENG   = 8;
  localparam int FLUSH_CYC = 2;
  // Engine i fires on the byte KEYS[i*8 +: 8].
  localparam logic [63:0] KEYS = {8'h21, 8'h2a, 8'h26, 8'h25, 8'h24, 8'h23, 8'h2d, 8'h40};

  typedef struct {
    logic [7:0]  m;
    int          len;
    logic [7:0]  b [16];
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [7:0]         s_data = 8'd0;
  logic               s_valid = 1'b0;
  logic               s_sop = 1'b0;
  logic               s_eop = 1'b0;
  logic               s_ready;
  logic [7:0]         eng_char;
  logic               eng_char_vld;
  logic               eng_en;
  logic               eng_sod;
  logic [NUM_ENG-1:0] eng_match = '0;
  logic               res_valid;
  logic               res_ready = 1'b1;
  logic [NUM_ENG-1:0] res_match;
  logic               res_any;
  logic [15:0]        res_len;
  logic [15:0]        drop_cnt;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   drop_model = 0;
  int   cur_len = 0;
  bit   rr_force_low = 1'b0;
  bit   rr_rand = 1'b0;
  bit   sp_en = 1'b0;

  payload_engine_ctrl #(.NUM_ENG(NUM_ENG), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop), .s_ready(s_ready),
    .eng_char(eng_char), .eng_char_vld(eng_char_vld), .eng_en(eng_en), .eng_sod(eng_sod),
    .eng_match(eng_match),
    .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match), .res_any(res_any),
    .res_len(res_len), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  function automatic logic [7:0] exp_match(input logic [7:0] b [16], input int n);
    logic [7:0] m = 8'd0;
    for (int j = 0; j < n; j++)
      for (int i = 0; i < NUM_ENG; i++)
        if (b[j] == KEYS[i*8 +: 8]) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [7:0] rand_byte();
    logic [63:0] k = KEYS;
    if ($urandom_range(0, 3) == 0) return k[$urandom_range(0, 7)*8 +: 8];
    return 8'(8'h41 + $urandom_range(0, 25));
  endfunction

  // Engine bank responder: sticky bits, cleared by eng_sod, updated on enabled data cycles.
  always @(posedge clk) begin
    if (eng_sod) eng_match <= '0;
    else if (eng_en && eng_char_vld)
      for (int i = 0; i < NUM_ENG; i++)
        if (eng_char == KEYS[i*8 +: 8]) eng_match[i] <= 1'b1;
  end

  // Result consumer.
  always @(posedge clk) begin
    #1;
    res_ready = rr_force_low ? 1'b0 : (rr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Monitor: decoupled from stimulus, pops the scoreboard on each result handshake.
  logic [7:0]  seen[$];
  int          flush_n = 0;
  int          sod_n = 0;
  bit          rst_prev = 1'b0;
  bit          after_rst = 1'b0;
  bit          hold_v = 1'b0;
  logic [7:0]  hold_m;
  logic        hold_any;
  logic [15:0] hold_len;
  int          last_sop = -1;
  int          last_len = 0;
  bit          sp_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_sod", eng_sod, 1);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_eng_en", eng_en, 0);
      chk("rst_char_vld", eng_char_vld, 0);
      chk("rst_res_valid", res_valid, 0);
      if (rst_prev) begin
        chk("rst_eng_char", eng_char, 0);
        chk("rst_res_match", res_match, 0);
        chk("rst_res_any", res_any, 0);
        chk("rst_res_len", res_len, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
      end
      seen.delete();
      flush_n   = 0;
      sod_n     = 0;
      hold_v    = 1'b0;
      after_rst = 1'b1;
      last_sop  = -1;
    end else begin
      if (after_rst) chk("sod_after_rst", eng_sod, 0);
      after_rst = 1'b0;
      if (eng_sod) begin
        seen.delete();
        flush_n = 0;
        sod_n++;
      end
      if (eng_en && eng_char_vld) seen.push_back(eng_char);
      if (eng_en && !eng_char_vld) flush_n++;
      if (res_valid) chk("report_s_ready", s_ready, 0);
      if (hold_v && res_valid) begin
        chk("hold_match", res_match, hold_m);
        chk("hold_any", res_any, hold_any);
        chk("hold_len", res_len, hold_len);
      end
      hold_v   = res_valid && !res_ready;
      hold_m   = res_match;
      hold_any = res_any;
      hold_len = res_len;
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", res_valid, 0);
        end else begin
          exp_t e;
          bit ok;
          e = sb.pop_front();
          chk("res_match", res_match, e.m);
          chk("res_any", res_any, (e.m != 0));
          chk("res_len", res_len, e.len);
          chk("data_en_cycles", seen.size(), e.len);
          ok = (seen.size() == e.len);
          for (int j = 0; j < e.len && ok; j++) if (seen[j] !== e.b[j]) ok = 1'b0;
          chk("eng_char_seq", ok, 1);
          chk("flush_cycles", flush_n, FLUSH_CYC);
          chk("sod_pulses", sod_n, 1);
        end
        sod_n = 0;
      end
      if (sp_en && !sp_prev) last_sop = -1;
      sp_prev = sp_en;
      if (s_valid && s_ready && s_sop) begin
        if (sp_en && last_sop >= 0) chk("sop_spacing", cyc - last_sop, last_len + FLUSH_CYC + 3);
        last_sop = cyc;
        last_len = cur_len;
      end
    end
    rst_prev = rst;
  end

  task automatic drive_beat(input logic [7:0] d, input bit sop, input bit eop);
    bit rdy;
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_sop   = sop;
    s_eop   = eop;
    forever begin
      @(negedge clk) rdy = s_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      t++;
      if (t > 200) begin
        fail_now("beat_accept");
        break;
      end
    end
    s_valid = 1'b0;
    s_sop   = 1'b0;
    s_eop   = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b [16], input int n, input bit gaps, input bit push);
    if (push) begin
      exp_t e;
      e.m   = exp_match(b, n);
      e.len = n;
      e.b   = b;
      sb.push_back(e);
    end
    cur_len = n;
    for (int i = 0; i < n; i++) begin
      drive_beat(b[i], (i == 0), (i == n - 1));
      if (gaps && i < n - 1) repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_results();
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      fail_now("result_wait");
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic stray(input int k);
    for (int i = 0; i < k; i++) begin
      drive_beat(rand_byte(), 1'b0, 1'b0);
      drop_model++;
    end
    @(negedge clk) chk("drop_cnt", drop_cnt, drop_model);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pkt(input int n, input bit gaps);
    logic [7:0] b [16];
    for (int i = 0; i < 16; i++) b[i] = rand_byte();
    send_pkt(b, n, gaps, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b [16];
    for (int i = 0; i < 16; i++) b[i] = 8'h41;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // "SSH-2.0"
    b[0] = 8'h53; b[1] = 8'h53; b[2] = 8'h48; b[3] = 8'h2d;
    b[4] = 8'h32; b[5] = 8'h2e; b[6] = 8'h30;
    send_pkt(b, 7, 1'b0, 1'b1);
    wait_results();
    @(negedge clk) chk("ssh_drop_cnt", drop_cnt, 0);

    // single-beat packet, sop and eop together
    b[0] = 8'h40;
    send_pkt(b, 1, 1'b0, 1'b1);
    wait_results();

    // stray beats in IDLE, then a normal packet
    stray(3);
    rand_pkt(5, 1'b0);
    wait_results();

    // gaps mid-packet, consumer stalls 5 cycles
    rr_force_low = 1'b1;
    rand_pkt(6, 1'b1);
    begin
      int t = 0;
      while (!res_valid && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (!res_valid) fail_now("stall_res_valid");
      repeat (5) @(negedge clk) chk("stall_held_valid", res_valid, 1);
    end
    rr_force_low = 1'b0;
    wait_results();

    // reset mid-SCAN after 4 bytes
    for (int i = 0; i < 4; i++) drive_beat(rand_byte(), (i == 0), 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    drop_model = 0;
    repeat (5) @(negedge clk) chk("abort_no_res_valid", res_valid, 0);
    rand_pkt(5, 1'b0);
    wait_results();
    @(negedge clk) chk("abort_drop_cnt", drop_cnt, 0);

    // back-to-back packets: sop-to-sop spacing
    sp_en = 1'b1;
    rand_pkt(3, 1'b0);
    rand_pkt(4, 1'b0);
    rand_pkt(2, 1'b0);
    wait_results();
    sp_en = 1'b0;

    // randomized traffic
    rr_rand = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 2) == 0) stray($urandom_range(1, 2));
      rand_pkt($urandom_range(1, 16), 1'b1);
      wait_results();
    end
    rr_rand = 1'b0;
    @(negedge clk) chk("final_drop_cnt", drop_cnt, drop_model);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
